iter_flag_ctrl: RTL and testbench

//  Iteration sequencer that drives a 1-bit status-flag register (wrt/dataIn pair) directly downstream.

---
 rtl/iter_flag_pkg.sv | 23 ++
 rtl/iter_counter.sv | 64 ++++++
 rtl/iter_flag_ctrl.sv | 146 ++++++++++++++
 tb/tb_iter_flag_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iter_flag_pkg.sv
// Shared definitions for the iteration/flag sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   ITER_CNT_W_DEFAULT       default counter / limit width
//   ST_IDLE/ST_RUN/ST_DONE   sequencer state codes
//   state_e                  enum built on those codes
package iter_flag_pkg;

  localparam int ITER_CNT_W_DEFAULT = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/iter_counter.sv
// Iteration counter with a latched limit and a terminal-match flag.
// Latency: cnt updates one cycle after load/clr/en; term is combinational from flops.
// Backpressure: none; en=0 simply holds the count.
//
// Ports:
//   clk, reset      clock, async active-low reset
//   load            latch limit_in and zero the count
//   limit_in        iteration limit to latch
//   clr             zero the count (wins over load and en)
//   en              advance the count by one
//   cnt             current count
//   term            next increment reaches the latched limit
module iter_counter
  import iter_flag_pkg::*;
#(
  parameter int CNT_W = ITER_CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] limit_in,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             term
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] limit_q, limit_d;
  logic [CNT_W-1:0] cnt_inc;

  // The controller only advances while cnt < limit, so cnt+1 can never
  // overflow even when limit is the all-ones maximum.
  assign cnt_inc = cnt_q + ONE;

  always_comb begin
    cnt_d   = cnt_q;
    limit_d = limit_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d   = '0;
      limit_d = limit_in;
    end else if (en) begin
      cnt_d = cnt_inc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      limit_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      limit_q <= limit_d;
    end
  end

  assign cnt  = cnt_q;
  assign term = (cnt_inc == limit_q);

endmodule

// File: rtl/iter_flag_ctrl.sv
// Iteration sequencer that counts num_iter iterations after start, then strobes a 1 into a downstream flag; clear strobes a 0.
// Latency: start accepted at edge E0 -> flag_wrt/flag_data high after edge E0+N (+1 per stalled cycle); clear -> strobe next cycle.
// Backpressure: optional stall (ITER_FLAG_STALL_EN) freezes RUN; start outside IDLE is dropped and latched into err.
//
// Ports:
//   clk, reset   clock, async active-low reset
//   start        begin a sequence (accepted only in IDLE)
//   clear        abort, zero the count, write 0 into the flag, clear err
//   num_iter     iteration count, latched on accepted start
//   stall        hold RUN (exists only when ITER_FLAG_STALL_EN is defined)
//   busy         high in RUN cycles
//   iter_cnt     completed iterations of the current sequence
//   err          sticky: start seen while not IDLE
//   flag_wrt     one-cycle write strobe to the flag register
//   flag_data    data accompanying flag_wrt
// Configuration macro: ITER_FLAG_STALL_EN
module iter_flag_ctrl
  import iter_flag_pkg::*;
#(
  parameter int CNT_W = ITER_CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             clear,
  input  logic [CNT_W-1:0] num_iter,
`ifdef ITER_FLAG_STALL_EN
  input  logic             stall,
`endif
  output logic             busy,
  output logic [CNT_W-1:0] iter_cnt,
  output logic             err,
  output logic             flag_wrt,
  output logic             flag_data
);

  state_e state_q, state_d;
  logic   busy_q, busy_d;
  logic   err_q, err_d;
  logic   flag_wrt_q, flag_wrt_d;
  logic   flag_data_q, flag_data_d;

  logic   cnt_load, cnt_clr, cnt_en;
  logic   cnt_term;
  logic   advance;

`ifdef ITER_FLAG_STALL_EN
  assign advance = ~stall;
`else
  assign advance = 1'b1;
`endif

  iter_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .limit_in (num_iter),
    .clr      (cnt_clr),
    .en       (cnt_en),
    .cnt      (iter_cnt),
    .term     (cnt_term)
  );

  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    flag_wrt_d  = 1'b0;
    flag_data_d = 1'b0;
    cnt_load    = 1'b0;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;

    if (clear) begin
      // Abort from any state, outranking a simultaneous start.
      state_d    = S_IDLE;
      cnt_clr    = 1'b1;
      err_d      = 1'b0;
      flag_wrt_d = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            cnt_load = 1'b1;
            if (num_iter == '0) begin
              // Zero-length sequence skips RUN and completes immediately.
              state_d     = S_DONE;
              flag_wrt_d  = 1'b1;
              flag_data_d = 1'b1;
            end else begin
              state_d = S_RUN;
            end
          end
        end
        S_RUN: begin
          if (start) begin
            err_d = 1'b1;
          end
          if (advance) begin
            cnt_en = 1'b1;
            if (cnt_term) begin
              state_d     = S_DONE;
              flag_wrt_d  = 1'b1;
              flag_data_d = 1'b1;
            end
          end
        end
        S_DONE: begin
          if (start) begin
            err_d = 1'b1;
          end
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // busy is registered alongside the state so it mirrors RUN exactly.
    busy_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      flag_wrt_q  <= 1'b0;
      flag_data_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      flag_wrt_q  <= flag_wrt_d;
      flag_data_q <= flag_data_d;
    end
  end

  assign busy      = busy_q;
  assign err       = err_q;
  assign flag_wrt  = flag_wrt_q;
  assign flag_data = flag_data_q;

endmodule

// File: tb/tb_iter_flag_ctrl.sv
// Self-checking bench for iter_flag_ctrl: directed scenarios plus a randomized run against a behavioural model.
// Latency: n/a.
// Backpressure: stall exercised only when ITER_FLAG_STALL_EN is defined.
module tb_iter_flag_ctrl;

  localparam int CNT_W = 16;
`ifdef ITER_FLAG_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             clear;
  logic [CNT_W-1:0] num_iter;
  logic             stall;
  logic             busy;
  logic [CNT_W-1:0] iter_cnt;
  logic             err;
  logic             flag_wrt;
  logic             flag_data;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: iterations still to run, a one-cycle "just finished" window, count and sticky error.
  int m_left;
  bit m_done;
  int m_cnt;
  bit m_err;
  bit m_wrt;
  bit m_data;

  always #5 clk = ~clk;

  iter_flag_ctrl #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .clear     (clear),
    .num_iter  (num_iter),
`ifdef ITER_FLAG_STALL_EN
    .stall     (stall),
`endif
    .busy      (busy),
    .iter_cnt  (iter_cnt),
    .err       (err),
    .flag_wrt  (flag_wrt),
    .flag_data (flag_data)
  );

  task automatic model_reset();
    m_left = 0; m_done = 1'b0; m_cnt = 0; m_err = 1'b0; m_wrt = 1'b0; m_data = 1'b0;
  endtask

  task automatic model_edge(input bit st, input bit cl, input int n, input bit sl);
    m_wrt  = 1'b0;
    m_data = 1'b0;
    if (cl) begin
      m_left = 0; m_done = 1'b0; m_cnt = 0; m_err = 1'b0; m_wrt = 1'b1;
    end else if (m_left > 0) begin
      if (st) m_err = 1'b1;
      if (!sl) begin
        m_cnt++;
        m_left--;
        if (m_left == 0) begin
          m_wrt = 1'b1; m_data = 1'b1; m_done = 1'b1;
        end
      end
    end else if (m_done) begin
      if (st) m_err = 1'b1;
      m_done = 1'b0;
    end else if (st) begin
      m_cnt = 0;
      if (n == 0) begin
        m_wrt = 1'b1; m_data = 1'b1; m_done = 1'b1;
      end else begin
        m_left = n;
      end
    end
  endtask

  // Drive one cycle of inputs, advance one edge, update the model; outputs are sampled #1 after the edge.
  task automatic step(input bit st, input bit cl, input int n, input bit sl);
    @(negedge clk);
    start    = st;
    clear    = cl;
    num_iter = CNT_W'(n);
    stall    = sl & STALL_EN;
    @(posedge clk);
    model_edge(st, cl, n, sl & STALL_EN);
    #1;
    start = 1'b0;
    clear = 1'b0;
    stall = 1'b0;
  endtask

  task automatic test_reset();
    if ({busy, err, flag_wrt, flag_data} !== 4'b0000 || iter_cnt !== '0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%0b err=%0b wrt=%0b data=%0b cnt=%0d want all 0",
               busy, err, flag_wrt, flag_data, iter_cnt);
    end
    checks++;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    step(0, 0, 0, 0);
    if ({busy, err, flag_wrt, flag_data} !== 4'b0000 || iter_cnt !== '0) begin
      failures++;
      $display("FAIL reset_idle got busy=%0b err=%0b wrt=%0b data=%0b cnt=%0d want all 0",
               busy, err, flag_wrt, flag_data, iter_cnt);
    end
    checks++;
  endtask

  task automatic test_basic();
    step(1, 0, 3, 0);
    if (busy !== 1'b1 || iter_cnt !== 16'd0 || flag_wrt !== 1'b0) begin
      failures++;
      $display("FAIL basic_accept got busy=%0b cnt=%0d wrt=%0b want 1 0 0", busy, iter_cnt, flag_wrt);
    end
    checks++;
    // num_iter wiggles during RUN; the latched limit of 3 must still govern.
    for (int j = 1; j <= 3; j++) begin
      step(0, 0, 7, 0);
      if (iter_cnt !== CNT_W'(j) || busy !== (j < 3) || flag_wrt !== (j == 3) || flag_data !== (j == 3)) begin
        failures++;
        $display("FAIL basic_iter%0d got cnt=%0d busy=%0b wrt=%0b data=%0b want cnt=%0d busy=%0b wrt=%0b data=%0b",
                 j, iter_cnt, busy, flag_wrt, flag_data, j, (j < 3), (j == 3), (j == 3));
      end
      checks++;
    end
    step(0, 0, 7, 0);
    if (busy !== 1'b0 || flag_wrt !== 1'b0 || iter_cnt !== 16'd3) begin
      failures++;
      $display("FAIL basic_after got busy=%0b wrt=%0b cnt=%0d want 0 0 3", busy, flag_wrt, iter_cnt);
    end
    checks++;
  endtask

  task automatic test_zero_iter();
    step(1, 0, 0, 0);
    if (busy !== 1'b0 || flag_wrt !== 1'b1 || flag_data !== 1'b1 || iter_cnt !== 16'd0) begin
      failures++;
      $display("FAIL zero_pulse got busy=%0b wrt=%0b data=%0b cnt=%0d want 0 1 1 0",
               busy, flag_wrt, flag_data, iter_cnt);
    end
    checks++;
    step(0, 0, 0, 0);
    if (busy !== 1'b0 || flag_wrt !== 1'b0) begin
      failures++;
      $display("FAIL zero_after got busy=%0b wrt=%0b want 0 0", busy, flag_wrt);
    end
    checks++;
  endtask

  task automatic test_err_clear();
    step(1, 0, 5, 0);
    step(0, 0, 5, 0);
    step(0, 0, 5, 0);
    step(1, 0, 1, 0);  // start at iter_cnt=2 is ignored
    if (err !== 1'b1 || iter_cnt !== 16'd3 || busy !== 1'b1) begin
      failures++;
      $display("FAIL err_set got err=%0b cnt=%0d busy=%0b want 1 3 1", err, iter_cnt, busy);
    end
    checks++;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    if (flag_wrt !== 1'b1 || flag_data !== 1'b1 || iter_cnt !== 16'd5 || err !== 1'b1) begin
      failures++;
      $display("FAIL err_complete got wrt=%0b data=%0b cnt=%0d err=%0b want 1 1 5 1",
               flag_wrt, flag_data, iter_cnt, err);
    end
    checks++;
    step(0, 0, 0, 0);
    if (err !== 1'b1 || busy !== 1'b0 || flag_wrt !== 1'b0) begin
      failures++;
      $display("FAIL err_sticky got err=%0b busy=%0b wrt=%0b want 1 0 0", err, busy, flag_wrt);
    end
    checks++;
    step(0, 1, 0, 0);
    if (err !== 1'b0 || flag_wrt !== 1'b1 || flag_data !== 1'b0 || iter_cnt !== 16'd0) begin
      failures++;
      $display("FAIL err_clear got err=%0b wrt=%0b data=%0b cnt=%0d want 0 1 0 0",
               err, flag_wrt, flag_data, iter_cnt);
    end
    checks++;
  endtask

  task automatic test_start_clear();
    step(1, 1, 4, 0);
    if (busy !== 1'b0 || flag_wrt !== 1'b1 || flag_data !== 1'b0) begin
      failures++;
      $display("FAIL sc_same got busy=%0b wrt=%0b data=%0b want 0 1 0", busy, flag_wrt, flag_data);
    end
    checks++;
    step(0, 0, 4, 0);
    if (busy !== 1'b0 || flag_wrt !== 1'b0 || iter_cnt !== 16'd0) begin
      failures++;
      $display("FAIL sc_idle got busy=%0b wrt=%0b cnt=%0d want 0 0 0", busy, flag_wrt, iter_cnt);
    end
    checks++;
  endtask

`ifdef ITER_FLAG_STALL_EN
  task automatic test_stall();
    step(1, 0, 4, 0);
    for (int j = 1; j <= 6; j++) begin
      step(0, 0, 4, (j == 2 || j == 3));
      if (flag_wrt !== (j == 6) || busy !== (j < 6)) begin
        failures++;
        $display("FAIL stall_cyc%0d got wrt=%0b busy=%0b want wrt=%0b busy=%0b",
                 j, flag_wrt, busy, (j == 6), (j < 6));
      end
      checks++;
    end
  endtask
`endif

  task automatic test_reset_mid_run();
    step(1, 0, 5, 0);
    step(0, 0, 5, 0);
    step(0, 0, 5, 0);
    if (iter_cnt !== 16'd2) begin
      failures++;
      $display("FAIL rmr_pre got cnt=%0d want 2", iter_cnt);
    end
    checks++;
    reset = 1'b0;
    #1;
    if ({busy, err, flag_wrt, flag_data} !== 4'b0000 || iter_cnt !== '0) begin
      failures++;
      $display("FAIL rmr_async got busy=%0b err=%0b wrt=%0b data=%0b cnt=%0d want all 0",
               busy, err, flag_wrt, flag_data, iter_cnt);
    end
    checks++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    for (int j = 0; j < 8; j++) begin
      step(0, 0, 0, 0);
      if (flag_wrt !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL rmr_quiet%0d got wrt=%0b busy=%0b want 0 0", j, flag_wrt, busy);
      end
      checks++;
    end
  endtask

  task automatic test_random();
    bit st, cl, sl;
    int n;
    for (int c = 0; c < 400; c++) begin
      st = ($urandom_range(0, 9) < 3);
      cl = ($urandom_range(0, 19) == 0);
      sl = ($urandom_range(0, 3) == 0);
      n  = $urandom_range(0, 5);
      step(st, cl, n, sl);
      if (busy !== (m_left > 0)) begin
        failures++;
        $display("FAIL rand_busy cyc=%0d got=%0b want=%0b", c, busy, (m_left > 0));
      end
      checks++;
      if (iter_cnt !== CNT_W'(m_cnt)) begin
        failures++;
        $display("FAIL rand_cnt cyc=%0d got=%0d want=%0d", c, iter_cnt, m_cnt);
      end
      checks++;
      if (err !== m_err) begin
        failures++;
        $display("FAIL rand_err cyc=%0d got=%0b want=%0b", c, err, m_err);
      end
      checks++;
      if (flag_wrt !== m_wrt || flag_data !== m_data) begin
        failures++;
        $display("FAIL rand_flag cyc=%0d got wrt=%0b data=%0b want wrt=%0b data=%0b",
                 c, flag_wrt, flag_data, m_wrt, m_data);
      end
      checks++;
    end
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    clear    = 1'b0;
    num_iter = '0;
    stall    = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_zero_iter();
    test_err_clear();
    test_start_clear();
`ifdef ITER_FLAG_STALL_EN
    test_stall();
`endif
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
